// File: rtl/hazard_scoreboard_if.sv
// ID-stage operand bus and hazard/forwarding results between the decode stage and the scoreboard.
interface hazard_scoreboard_if #(
  parameter int unsigned REG_AW = 3,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned FW = $clog2(DEPTH + 1);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwr;
  logic              id_memrd;
  logic              id_br_taken;
  logic              cnt_clr;
  logic              stall;
  logic              kill;
  logic              id_squash;
  logic [FW-1:0]     fwd_a;
  logic [FW-1:0]     fwd_b;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  kill_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwr, id_memrd, id_br_taken, cnt_clr,
    input  stall, kill, id_squash, fwd_a, fwd_b, stall_cnt, kill_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwr, id_memrd, id_br_taken, cnt_clr,
    output stall, kill, id_squash, fwd_a, fwd_b, stall_cnt, kill_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Parametrised hazard/forwarding unit: shift scoreboard of in-flight writes after ID,
// producing forwarding selects, load-use stalls, branch kill/squash and perf counters.
module hazard_scoreboard #(
  parameter int unsigned REG_AW      = 3,
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned LOAD_STAGE  = 2,
  parameter int unsigned ZERO_REG_EN = 0,
  parameter int unsigned CNT_W       = 16
) (
  input logic               clk,
  input logic               rst_n,
  hazard_scoreboard_if.slave bus
);
  localparam int unsigned FW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              regwr;
    logic              memrd;
  } entry_t;

  // sb[i] holds stage i+1 (sb[0] = EX, sb[DEPTH-1] = WB)
  entry_t            sb [DEPTH];
  logic              squash_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  kill_cnt_q;

  logic              pre_valid;
  logic              eff_valid;
  logic              stall_c;
  logic              kill_c;
  logic [REG_AW-1:0] src     [2];
  logic              use_src [2];
  logic              hz      [2];
  logic [FW-1:0]     fw      [2];

  assign src[0]     = bus.id_rs1;
  assign src[1]     = bus.id_rs2;
  assign use_src[0] = bus.id_use_rs1;
  assign use_src[1] = bus.id_use_rs2;

  // Youngest matching stage wins: scan oldest to youngest, last hit overrides.
  always_comb begin : lookup
    for (int j = 0; j < 2; j++) begin
      hz[j] = 1'b0;
      fw[j] = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
        if (sb[i].v && sb[i].regwr && (sb[i].rd == src[j])) begin
          fw[j] = FW'(i + 1);
          hz[j] = sb[i].memrd && ((i + 1) < int'(LOAD_STAGE));
        end
      end
      if (!use_src[j] || ((ZERO_REG_EN != 0) && (src[j] == '0))) begin
        hz[j] = 1'b0;
        fw[j] = '0;
      end
    end
  end

  // A squashed ID slot is ignored entirely, so it can neither stall nor kill.
  assign pre_valid = bus.id_valid & ~squash_q;
  assign stall_c   = pre_valid & (hz[0] | hz[1]);
  assign eff_valid = pre_valid & ~stall_c;
  assign kill_c    = eff_valid & bus.id_br_taken;

  assign bus.stall     = stall_c;
  assign bus.kill      = kill_c;
  assign bus.fwd_a     = eff_valid ? fw[0] : '0;
  assign bus.fwd_b     = eff_valid ? fw[1] : '0;
  assign bus.id_squash = squash_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.kill_cnt  = kill_cnt_q;

  // Scoreboard shift, squash flag and saturating counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) sb[i] <= '0;
      squash_q    <= 1'b0;
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      if (eff_valid) begin
        sb[0] <= '{v: 1'b1, rd: bus.id_rd, regwr: bus.id_regwr, memrd: bus.id_memrd};
      end else begin
        sb[0] <= '0;
      end
      for (int i = int'(DEPTH) - 1; i > 0; i--) sb[i] <= sb[i-1];
      squash_q <= kill_c;

      if (bus.cnt_clr)                          stall_cnt_q <= '0;
      else if (stall_c && (stall_cnt_q != '1))  stall_cnt_q <= stall_cnt_q + CNT_W'(1);

      if (bus.cnt_clr)                          kill_cnt_q <= '0;
      else if (kill_c && (kill_cnt_q != '1))    kill_cnt_q <= kill_cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: four configurations share one ID stimulus stream.
module tb_hazard_scoreboard;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use_rs1, id_use_rs2, id_regwr, id_memrd, id_br_taken, cnt_clr;
  logic [2:0] id_rs1, id_rs2, id_rd;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(3), .DEPTH(3), .CNT_W(16)) i0 ();
  hazard_scoreboard_if #(.REG_AW(3), .DEPTH(4), .CNT_W(16)) i1 ();
  hazard_scoreboard_if #(.REG_AW(3), .DEPTH(3), .CNT_W(16)) i2 ();
  hazard_scoreboard_if #(.REG_AW(3), .DEPTH(3), .CNT_W(2))  i3 ();

  assign {i0.id_valid, i0.id_rs1, i0.id_rs2, i0.id_use_rs1, i0.id_use_rs2, i0.id_rd, i0.id_regwr, i0.id_memrd, i0.id_br_taken, i0.cnt_clr} =
         {id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwr, id_memrd, id_br_taken, cnt_clr};
  assign {i1.id_valid, i1.id_rs1, i1.id_rs2, i1.id_use_rs1, i1.id_use_rs2, i1.id_rd, i1.id_regwr, i1.id_memrd, i1.id_br_taken, i1.cnt_clr} =
         {id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwr, id_memrd, id_br_taken, cnt_clr};
  assign {i2.id_valid, i2.id_rs1, i2.id_rs2, i2.id_use_rs1, i2.id_use_rs2, i2.id_rd, i2.id_regwr, i2.id_memrd, i2.id_br_taken, i2.cnt_clr} =
         {id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwr, id_memrd, id_br_taken, cnt_clr};
  assign {i3.id_valid, i3.id_rs1, i3.id_rs2, i3.id_use_rs1, i3.id_use_rs2, i3.id_rd, i3.id_regwr, i3.id_memrd, i3.id_br_taken, i3.cnt_clr} =
         {id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwr, id_memrd, id_br_taken, cnt_clr};

  hazard_scoreboard #(.REG_AW(3), .DEPTH(3), .LOAD_STAGE(2), .ZERO_REG_EN(0), .CNT_W(16))
    u0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
  hazard_scoreboard #(.REG_AW(3), .DEPTH(4), .LOAD_STAGE(3), .ZERO_REG_EN(0), .CNT_W(16))
    u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  hazard_scoreboard #(.REG_AW(3), .DEPTH(3), .LOAD_STAGE(2), .ZERO_REG_EN(1), .CNT_W(16))
    u2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));
  hazard_scoreboard #(.REG_AW(3), .DEPTH(3), .LOAD_STAGE(2), .ZERO_REG_EN(0), .CNT_W(2))
    u3 (.clk(clk), .rst_n(rst_n), .bus(i3.slave));

  task automatic setid(input logic v, input logic [2:0] a, input logic [2:0] b, input logic ua,
                       input logic ub, input logic [2:0] d, input logic w, input logic m, input logic br);
    id_valid = v; id_rs1 = a; id_rs2 = b; id_use_rs1 = ua; id_use_rs2 = ub;
    id_rd = d; id_regwr = w; id_memrd = m; id_br_taken = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cnt_clr = 1'b0;
    setid(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(); #1;
    checks++; if (i0.stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0d exp=0", i0.stall); end
    checks++; if (i0.kill !== 1'b0) begin failures++; $display("FAIL rst_kill got=%0d exp=0", i0.kill); end
    checks++; if (i0.id_squash !== 1'b0) begin failures++; $display("FAIL rst_squash got=%0d exp=0", i0.id_squash); end
    checks++; if (i0.fwd_a !== 2'd0 || i0.fwd_b !== 2'd0) begin failures++; $display("FAIL rst_fwd got=%0d/%0d exp=0/0", i0.fwd_a, i0.fwd_b); end
    checks++; if (i0.stall_cnt !== 16'd0 || i0.kill_cnt !== 16'd0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", i0.stall_cnt, i0.kill_cnt); end
    setid(1, 1, 2, 1, 1, 0, 0, 0, 1); #1;
    checks++; if (i0.kill !== 1'b1) begin failures++; $display("FAIL rst_prekill got=%0d exp=1", i0.kill); end
    rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
    checks++; if (i0.id_squash !== 1'b0) begin failures++; $display("FAIL rst_midkill_squash got=%0d exp=0", i0.id_squash); end
    checks++; if (i0.kill !== 1'b1) begin failures++; $display("FAIL rst_after_kill got=%0d exp=1", i0.kill); end
    checks++; if (i0.kill_cnt !== 16'd0) begin failures++; $display("FAIL rst_midkill_cnt got=%0d exp=0", i0.kill_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    setid(1, 2, 3, 1, 1, 1, 1, 0, 0); tick();
    setid(1, 1, 1, 1, 1, 2, 1, 0, 0); #1;
    checks++; if (i0.fwd_a !== 2'd1 || i0.fwd_b !== 2'd1) begin failures++; $display("FAIL b2b_fwd got=%0d/%0d exp=1/1", i0.fwd_a, i0.fwd_b); end
    checks++; if (i0.stall !== 1'b0) begin failures++; $display("FAIL b2b_stall got=%0d exp=0", i0.stall); end
    tick();
    setid(1, 1, 4, 1, 0, 3, 1, 0, 0); #1;
    checks++; if (i0.fwd_a !== 2'd2 || i0.fwd_b !== 2'd0) begin failures++; $display("FAIL b2b_fwd2 got=%0d/%0d exp=2/0", i0.fwd_a, i0.fwd_b); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    setid(1, 1, 0, 1, 0, 3, 1, 1, 0); tick();
    setid(1, 3, 0, 1, 1, 4, 1, 0, 0); #1;
    checks++; if (i0.stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0d exp=1", i0.stall); end
    checks++; if (i0.fwd_a !== 2'd0) begin failures++; $display("FAIL lu_fwd_gated got=%0d exp=0", i0.fwd_a); end
    tick();
    checks++; if (i0.stall !== 1'b0) begin failures++; $display("FAIL lu_release got=%0d exp=0", i0.stall); end
    checks++; if (i0.fwd_a !== 2'd2 || i0.fwd_b !== 2'd0) begin failures++; $display("FAIL lu_fwd got=%0d/%0d exp=2/0", i0.fwd_a, i0.fwd_b); end
    checks++; if (i0.stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", i0.stall_cnt); end
    setid(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
  endtask

  task automatic test_deep_load();
    do_reset();
    setid(1, 1, 0, 1, 0, 5, 1, 1, 0); tick();
    setid(1, 5, 5, 1, 1, 6, 1, 0, 0); #1;
    checks++; if (i1.stall !== 1'b1) begin failures++; $display("FAIL deep_stall1 got=%0d exp=1", i1.stall); end
    tick();
    checks++; if (i1.stall !== 1'b1) begin failures++; $display("FAIL deep_stall2 got=%0d exp=1", i1.stall); end
    tick();
    checks++; if (i1.stall !== 1'b0) begin failures++; $display("FAIL deep_release got=%0d exp=0", i1.stall); end
    checks++; if (i1.fwd_a !== 3'd3 || i1.fwd_b !== 3'd3) begin failures++; $display("FAIL deep_fwd got=%0d/%0d exp=3/3", i1.fwd_a, i1.fwd_b); end
    checks++; if (i1.stall_cnt !== 16'd2) begin failures++; $display("FAIL deep_cnt got=%0d exp=2", i1.stall_cnt); end
    tick();
    setid(1, 6, 5, 1, 1, 7, 1, 0, 0); #1;
    checks++; if (i1.fwd_a !== 3'd1 || i1.fwd_b !== 3'd4) begin failures++; $display("FAIL deep_pos got=%0d/%0d exp=1/4", i1.fwd_a, i1.fwd_b); end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    setid(1, 1, 2, 1, 1, 0, 0, 0, 1); #1;
    checks++; if (i0.kill !== 1'b1 || i0.stall !== 1'b0) begin failures++; $display("FAIL br_kill got=%0d/%0d exp=1/0", i0.kill, i0.stall); end
    tick();
    setid(1, 1, 2, 1, 1, 1, 1, 0, 1); #1;
    checks++; if (i0.id_squash !== 1'b1) begin failures++; $display("FAIL br_squash got=%0d exp=1", i0.id_squash); end
    checks++; if (i0.kill !== 1'b0) begin failures++; $display("FAIL br_squash_kill got=%0d exp=0", i0.kill); end
    tick();
    setid(1, 1, 0, 1, 0, 2, 1, 0, 0); #1;
    checks++; if (i0.id_squash !== 1'b0) begin failures++; $display("FAIL br_squash_end got=%0d exp=0", i0.id_squash); end
    checks++; if (i0.fwd_a !== 2'd0) begin failures++; $display("FAIL br_bubble got=%0d exp=0", i0.fwd_a); end
    checks++; if (i0.kill_cnt !== 16'd1) begin failures++; $display("FAIL br_cnt got=%0d exp=1", i0.kill_cnt); end
    do_reset();
    setid(1, 1, 0, 1, 0, 3, 1, 1, 0); tick();
    setid(1, 3, 0, 1, 0, 0, 0, 0, 1); #1;
    checks++; if (i0.stall !== 1'b1 || i0.kill !== 1'b0) begin failures++; $display("FAIL brlu_hold got=%0d/%0d exp=1/0", i0.stall, i0.kill); end
    tick();
    checks++; if (i0.stall !== 1'b0 || i0.kill !== 1'b1) begin failures++; $display("FAIL brlu_release got=%0d/%0d exp=0/1", i0.stall, i0.kill); end
    checks++; if (i0.fwd_a !== 2'd2) begin failures++; $display("FAIL brlu_fwd got=%0d exp=2", i0.fwd_a); end
    tick();
    setid(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (i0.id_squash !== 1'b1) begin failures++; $display("FAIL brlu_squash got=%0d exp=1", i0.id_squash); end
    checks++; if (i0.kill_cnt !== 16'd1 || i0.stall_cnt !== 16'd1) begin failures++; $display("FAIL brlu_cnt got=%0d/%0d exp=1/1", i0.kill_cnt, i0.stall_cnt); end
    tick();
  endtask

  task automatic test_zero_reg();
    do_reset();
    setid(1, 0, 0, 0, 0, 0, 1, 1, 0); tick();
    setid(1, 0, 0, 1, 1, 2, 1, 0, 0); #1;
    checks++; if (i2.stall !== 1'b0) begin failures++; $display("FAIL zero_stall got=%0d exp=0", i2.stall); end
    checks++; if (i2.fwd_a !== 2'd0 || i2.fwd_b !== 2'd0) begin failures++; $display("FAIL zero_fwd got=%0d/%0d exp=0/0", i2.fwd_a, i2.fwd_b); end
    checks++; if (i0.stall !== 1'b1) begin failures++; $display("FAIL zero_off_stall got=%0d exp=1", i0.stall); end
    tick();
    setid(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    setid(1, 0, 0, 0, 0, 2, 1, 0, 0); tick();
    setid(1, 2, 0, 1, 0, 3, 1, 0, 0); #1;
    checks++; if (i2.fwd_a !== 2'd1) begin failures++; $display("FAIL zero_youngest got=%0d exp=1", i2.fwd_a); end
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    setid(1, 1, 0, 1, 0, 1, 1, 1, 0);
    repeat (10) tick();
    checks++; if (i3.stall_cnt !== 2'd3) begin failures++; $display("FAIL sat_hold got=%0d exp=3", i3.stall_cnt); end
    checks++; if (i0.stall_cnt !== 16'd5) begin failures++; $display("FAIL sat_wide got=%0d exp=5", i0.stall_cnt); end
    tick();
    cnt_clr = 1'b1; #1;
    checks++; if (i3.stall !== 1'b1) begin failures++; $display("FAIL sat_clr_stall got=%0d exp=1", i3.stall); end
    tick();
    cnt_clr = 1'b0;
    checks++; if (i3.stall_cnt !== 2'd0) begin failures++; $display("FAIL sat_clr got=%0d exp=0", i3.stall_cnt); end
    tick();
    checks++; if (i3.stall !== 1'b1) begin failures++; $display("FAIL sat_restall got=%0d exp=1", i3.stall); end
    rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
    checks++; if (i3.stall !== 1'b0 || i3.stall_cnt !== 2'd0) begin failures++; $display("FAIL sat_rst got=%0d/%0d exp=0/0", i3.stall, i3.stall_cnt); end
    setid(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_deep_load();
    test_branch();
    test_zero_reg();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
